// File: rtl/mcu_spi_pkg.sv
// Shared definitions for the MCU SPI link: target codes and link FSM states.
package mcu_spi_pkg;

  localparam logic [7:0] TGT_SYS = 8'd0;
  localparam logic [7:0] TGT_HID = 8'd1;
  localparam logic [7:0] TGT_OSD = 8'd2;
  localparam logic [7:0] TGT_SDC = 8'd3;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    TARGET,
    CMD,
    DATA
  } link_state_t;

endpackage

// File: rtl/spi_sync.sv
// 2-flop synchroniser for one asynchronous SPI pin, with optional edge detect.
// Latency 2 clk to the synced level, edges one history flop later; no backpressure.
module spi_sync #(
  parameter bit EDGE_DET = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) meta <= 2'b00;
    else       meta <= {meta[0], din};
  end

  assign sync = meta[1];

  generate
    if (EDGE_DET) begin : g_edge
      logic hist;
      always_ff @(posedge clk) begin
        if (reset) hist <= 1'b0;
        else       hist <= meta[1];
      end
      assign rise = meta[1] & ~hist;
      assign fall = ~meta[1] & hist;
    end else begin : g_plain
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mcu_spi_link.sv
// SPI slave from the IO MCU: target byte selects a consumer, later bytes go out as strobes.
// Strobe 4 clk after the 8th SCK rise; no backpressure, consumers must take each byte.
module mcu_spi_link
  import mcu_spi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_io_ss,
  input  logic       spi_io_clk,
  input  logic       spi_io_din,
  output logic       spi_io_dout,
  output logic       mcu_start,
  output logic [7:0] mcu_dout,
  output logic       mcu_sys_strobe,
  output logic       mcu_hid_strobe,
  output logic       mcu_osd_strobe,
  output logic       mcu_sdc_strobe,
  input  logic [7:0] mcu_sys_din,
  input  logic [7:0] mcu_hid_din,
  input  logic [7:0] mcu_osd_din,
  input  logic [7:0] mcu_sdc_din
);

  logic ss_s, ss_rise_unused, ss_fall_unused;
  logic sck_rise, sck_fall, sck_level_unused;
  logic din_s, din_rise_unused, din_fall_unused;

  spi_sync u_ss  (.clk(clk), .reset(reset), .din(spi_io_ss),  .sync(ss_s),
                  .rise(ss_rise_unused), .fall(ss_fall_unused));
  spi_sync u_sck (.clk(clk), .reset(reset), .din(spi_io_clk), .sync(sck_level_unused),
                  .rise(sck_rise), .fall(sck_fall));
  spi_sync #(.EDGE_DET(1'b0)) u_din (.clk(clk), .reset(reset), .din(spi_io_din), .sync(din_s),
                  .rise(din_rise_unused), .fall(din_fall_unused));

  link_state_t state;
  logic [7:0]  target;
  logic [7:0]  rx_shift;
  logic [6:0]  tx_shift;
  logic [2:0]  bit_cnt;
  logic        byte_done;
  logic        load_pend;
  logic [3:0]  strobe_q;
  logic [7:0]  sel_din;
  logic        tgt_ok;
  logic        tx_en;

  always_comb begin
    sel_din = 8'h00;
    tgt_ok  = 1'b1;
    case (target)
      TGT_SYS: sel_din = mcu_sys_din;
      TGT_HID: sel_din = mcu_hid_din;
      TGT_OSD: sel_din = mcu_osd_din;
      TGT_SDC: sel_din = mcu_sdc_din;
      default: tgt_ok  = 1'b0;
    endcase
  end

  // MISO only carries reply data once a valid target has been latched.
  assign tx_en = tgt_ok && (state == CMD || state == DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_IDLE;
      target      <= 8'h00;
      rx_shift    <= 8'h00;
      tx_shift    <= 7'h00;
      bit_cnt     <= 3'd0;
      byte_done   <= 1'b0;
      load_pend   <= 1'b0;
      strobe_q    <= 4'b0000;
      mcu_start   <= 1'b0;
      mcu_dout    <= 8'h00;
      spi_io_dout <= 1'b0;
    end else begin
      strobe_q  <= 4'b0000;
      mcu_start <= 1'b0;
      byte_done <= 1'b0;
      // Deselect wins over everything, including a byte completing this cycle.
      if (ss_s) begin
        state       <= TARGET;
        bit_cnt     <= 3'd0;
        rx_shift    <= 8'h00;
        tx_shift    <= 7'h00;
        load_pend   <= 1'b0;
        spi_io_dout <= 1'b0;
      end else if (state != WAIT_IDLE) begin
        if (sck_rise) begin
          rx_shift <= {rx_shift[6:0], din_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done <= 1'b1;
            load_pend <= 1'b1;
          end
        end
        if (sck_fall) begin
          if (load_pend) begin
            load_pend   <= 1'b0;
            tx_shift    <= sel_din[6:0];
            spi_io_dout <= tx_en & sel_din[7];
          end else begin
            tx_shift    <= {tx_shift[5:0], 1'b0};
            spi_io_dout <= tx_en & tx_shift[6];
          end
        end
        if (byte_done) begin
          case (state)
            TARGET: begin
              target <= rx_shift;
              state  <= CMD;
            end
            CMD, DATA: begin
              if (tgt_ok) begin
                strobe_q  <= 4'b0001 << target[1:0];
                mcu_start <= (state == CMD);
                mcu_dout  <= rx_shift;
              end
              state <= DATA;
            end
            default: state <= state;
          endcase
        end
      end
    end
  end

  assign mcu_sys_strobe = strobe_q[0];
  assign mcu_hid_strobe = strobe_q[1];
  assign mcu_osd_strobe = strobe_q[2];
  assign mcu_sdc_strobe = strobe_q[3];

endmodule

// File: tb/tb_mcu_spi_link.sv
// Directed bench for mcu_spi_link: SPI frames driven at clk/8, strobes and MISO scored.
module tb_mcu_spi_link;

  logic       clk, reset;
  logic       spi_io_ss, spi_io_clk, spi_io_din, spi_io_dout;
  logic       mcu_start;
  logic [7:0] mcu_dout;
  logic       mcu_sys_strobe, mcu_hid_strobe, mcu_osd_strobe, mcu_sdc_strobe;
  logic [7:0] mcu_sys_din, mcu_hid_din, mcu_osd_din, mcu_sdc_din;

  mcu_spi_link dut (
    .clk(clk), .reset(reset),
    .spi_io_ss(spi_io_ss), .spi_io_clk(spi_io_clk), .spi_io_din(spi_io_din),
    .spi_io_dout(spi_io_dout), .mcu_start(mcu_start), .mcu_dout(mcu_dout),
    .mcu_sys_strobe(mcu_sys_strobe), .mcu_hid_strobe(mcu_hid_strobe),
    .mcu_osd_strobe(mcu_osd_strobe), .mcu_sdc_strobe(mcu_sdc_strobe),
    .mcu_sys_din(mcu_sys_din), .mcu_hid_din(mcu_hid_din),
    .mcu_osd_din(mcu_osd_din), .mcu_sdc_din(mcu_sdc_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  // Strobe event log, captured away from the active edge.
  logic [3:0] ev_stb[$];
  logic       ev_start[$];
  logic [7:0] ev_dout[$];
  logic [3:0] mon_stb;
  logic       sys_cnt_en;
  logic [7:0] sys_cnt;
  logic [7:0] sys_reply;

  // sys consumer either holds a fixed reply or counts up on each of its strobes.
  assign mcu_sys_din = sys_cnt_en ? sys_cnt : sys_reply;

  always @(negedge clk) begin
    mon_stb = {mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe};
    if (mon_stb != 4'b0000) begin
      ev_stb.push_back(mon_stb);
      ev_start.push_back(mcu_start);
      ev_dout.push_back(mcu_dout);
    end
    if (!sys_cnt_en) sys_cnt = 8'h01;
    else if (mcu_sys_strobe) sys_cnt = sys_cnt + 8'h01;
  end

  logic [7:0] tx_bytes[8];
  logic [7:0] rx_miso[8];
  logic [7:0] scratch;

  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] m);
    m = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_io_din = b[i];
      #40;
      m[i] = spi_io_dout;
      spi_io_clk = 1'b1;
      #40;
      spi_io_clk = 1'b0;
    end
  endtask

  task automatic send_frame(input int n);
    logic [7:0] m;
    spi_io_ss = 1'b0;
    #40;
    for (int k = 0; k < n; k++) begin
      spi_bits(tx_bytes[k], 8, m);
      rx_miso[k] = m;
    end
    #80;
    spi_io_ss = 1'b1;
    #160;
  endtask

  typedef struct {
    int               n;
    logic [0:7][7:0]  b;
    int               sel;       // target index whose din carries reply, -1 = all
    logic [3:0]       exp_stb;
    int               exp_cnt;
    logic [7:0]       reply;
    logic [7:0]       exp_miso;
  } vec_t;

  vec_t vecs[6];
  int   base;
  logic [7:0] held_dout;

  initial begin
    vecs[0] = '{3, {8'h01, 8'h01, 8'h77, 40'h0},                          1, 4'b0010, 2, 8'h5A, 8'h5A};
    vecs[1] = '{7, {8'h01, 8'h03, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 8'h0}, 1, 4'b0010, 6, 8'hC3, 8'hC3};
    vecs[2] = '{4, {8'h07, 8'h11, 8'h22, 8'h33, 32'h0},                   -1, 4'b0000, 0, 8'h5A, 8'h00};
    vecs[3] = '{3, {8'h00, 8'hA5, 8'h3C, 40'h0},                           0, 4'b0001, 2, 8'h96, 8'h96};
    vecs[4] = '{4, {8'h03, 8'h42, 8'hFF, 8'h18, 32'h0},                    3, 4'b1000, 3, 8'hB1, 8'hB1};
    vecs[5] = '{2, {8'h02, 8'h10, 48'h0},                                  2, 4'b0100, 1, 8'h6C, 8'h6C};

    spi_io_ss = 1'b1; spi_io_clk = 1'b0; spi_io_din = 1'b0;
    sys_cnt_en = 1'b0; sys_reply = 8'h00;
    mcu_hid_din = 8'h00; mcu_osd_din = 8'h00; mcu_sdc_din = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #10;

    chk("reset_strobes", {28'h0, mcu_sdc_strobe, mcu_osd_strobe, mcu_hid_strobe, mcu_sys_strobe}, 0);
    chk("reset_start", {31'h0, mcu_start}, 0);
    chk("reset_dout", {24'h0, mcu_dout}, 0);
    chk("reset_miso", {31'h0, spi_io_dout}, 0);
    #100;

    held_dout = 8'h00;
    for (int v = 0; v < 6; v++) begin
      sys_reply   = (vecs[v].sel == 0 || vecs[v].sel < 0) ? vecs[v].reply : 8'hE7;
      mcu_hid_din = (vecs[v].sel == 1 || vecs[v].sel < 0) ? vecs[v].reply : 8'hE7;
      mcu_osd_din = (vecs[v].sel == 2 || vecs[v].sel < 0) ? vecs[v].reply : 8'hE7;
      mcu_sdc_din = (vecs[v].sel == 3 || vecs[v].sel < 0) ? vecs[v].reply : 8'hE7;
      for (int k = 0; k < 8; k++) tx_bytes[k] = vecs[v].b[k];
      base = ev_stb.size();
      send_frame(vecs[v].n);
      chk($sformatf("v%0d_strobe_count", v), ev_stb.size() - base, vecs[v].exp_cnt);
      for (int e = 0; e < ev_stb.size() - base && e < 7; e++) begin
        chk($sformatf("v%0d_e%0d_which", v, e), {28'h0, ev_stb[base+e]}, {28'h0, vecs[v].exp_stb});
        chk($sformatf("v%0d_e%0d_start", v, e), {31'h0, ev_start[base+e]}, (e == 0) ? 1 : 0);
        chk($sformatf("v%0d_e%0d_dout", v, e), {24'h0, ev_dout[base+e]}, {24'h0, vecs[v].b[e+1]});
      end
      for (int k = 0; k < vecs[v].n; k++)
        chk($sformatf("v%0d_miso_b%0d", v, k), {24'h0, rx_miso[k]},
            (k == 0) ? 32'h0 : {24'h0, vecs[v].exp_miso});
      if (vecs[v].exp_cnt > 0) held_dout = vecs[v].b[vecs[v].n - 1];
      chk($sformatf("v%0d_dout_held", v), {24'h0, mcu_dout}, {24'h0, held_dout});
      chk($sformatf("v%0d_miso_idle", v), {31'h0, spi_io_dout}, 0);
    end

    // Frame aborted 5 bits into its second byte, then a clean osd frame.
    base = ev_stb.size();
    mcu_osd_din = 8'h3E;
    spi_io_ss = 1'b0;
    #40;
    spi_bits(8'h01, 8, scratch);
    spi_bits(8'hFF, 5, scratch);
    #40;
    spi_io_ss = 1'b1;
    #160;
    chk("abort_no_strobe", ev_stb.size() - base, 0);
    tx_bytes[0] = 8'h02; tx_bytes[1] = 8'h10;
    send_frame(2);
    chk("abort_next_count", ev_stb.size() - base, 1);
    if (ev_stb.size() > base) begin
      chk("abort_next_which", {28'h0, ev_stb[base]}, 32'h4);
      chk("abort_next_start", {31'h0, ev_start[base]}, 1);
      chk("abort_next_dout", {24'h0, ev_dout[base]}, 32'h10);
    end

    // Reset pulsed mid-byte with ss held low: the rest of that frame is ignored.
    sys_reply = 8'h00;
    base = ev_stb.size();
    spi_io_ss = 1'b0;
    #40;
    spi_bits(8'h00, 8, scratch);
    spi_bits(8'h55, 8, scratch);
    spi_bits(8'hAA, 3, scratch);
    #80;
    chk("rst_pre_count", ev_stb.size() - base, 1);
    base = ev_stb.size();
    reset = 1'b1;
    #20;
    reset = 1'b0;
    spi_bits(8'h15, 5, scratch);
    spi_bits(8'h66, 8, scratch);
    spi_bits(8'h00, 8, scratch);
    #80;
    chk("rst_ignored_count", ev_stb.size() - base, 0);
    chk("rst_dout_cleared", {24'h0, mcu_dout}, 0);
    spi_io_ss = 1'b1;
    #160;
    tx_bytes[0] = 8'h00; tx_bytes[1] = 8'h00;
    send_frame(2);
    chk("rst_next_count", ev_stb.size() - base, 1);
    if (ev_stb.size() > base) begin
      chk("rst_next_which", {28'h0, ev_stb[base]}, 32'h1);
      chk("rst_next_start", {31'h0, ev_start[base]}, 1);
    end

    // Back-to-back bytes with a reply that advances on every sys strobe.
    sys_cnt_en = 1'b1;
    #20;
    base = ev_stb.size();
    tx_bytes[0] = 8'h00; tx_bytes[1] = 8'hAA; tx_bytes[2] = 8'hBB; tx_bytes[3] = 8'hCC;
    send_frame(4);
    chk("b2b_count", ev_stb.size() - base, 3);
    chk("b2b_miso_b0", {24'h0, rx_miso[0]}, 32'h00);
    chk("b2b_miso_b1", {24'h0, rx_miso[1]}, 32'h01);
    chk("b2b_miso_b2", {24'h0, rx_miso[2]}, 32'h02);
    chk("b2b_miso_b3", {24'h0, rx_miso[3]}, 32'h03);
    for (int e = 0; e < ev_stb.size() - base && e < 3; e++) begin
      chk($sformatf("b2b_e%0d_which", e), {28'h0, ev_stb[base+e]}, 32'h1);
      chk($sformatf("b2b_e%0d_dout", e), {24'h0, ev_dout[base+e]}, {24'h0, tx_bytes[e+1]});
    end
    sys_cnt_en = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mcu_spi_link.md
# mcu_spi_link

SPI slave link between the IO MCU and the FPGA core. Deserialises MCU SPI frames in the system clock domain, decodes the leading target byte, and delivers the remaining bytes as byte strobes plus a frame-start flag to the selected consumer (sys, hid, osd, sdc). It also shifts the selected consumer's reply byte back to the MCU. It sits directly upstream of the hid block and drives that block's strobe, start and data inputs.

## Interface
- No parameters.
- `clk` in 1: system clock; must be ≥ 8× the SPI clock rate.
- `reset` in 1: synchronous, active-high.
- `spi_io_ss` in 1: chip select, active low, asynchronous to `clk`.
- `spi_io_clk` in 1: SPI clock, mode 0, asynchronous.
- `spi_io_din` in 1: MOSI, asynchronous.
- `spi_io_dout` out 1: MISO.
- `mcu_start` out 1: asserted together with the first strobe of a frame (the command byte).
- `mcu_dout` out 8: received byte; valid while any strobe is high.
- `mcu_sys_strobe`, `mcu_hid_strobe`, `mcu_osd_strobe`, `mcu_sdc_strobe` out 1 each: one-cycle byte strobes, one per target.
- `mcu_sys_din`, `mcu_hid_din`, `mcu_osd_din`, `mcu_sdc_din` in 8 each: reply byte from each target.

## Operation
- Synchroniser: `spi_io_ss`, `spi_io_clk` and `spi_io_din` each pass through 2 flops, plus 1 history flop on ss and clk for edge detection.
- SCK rising edge, ss low: shift `din` into `rx_shift`, MSB first, and increment the 3-bit `bit_cnt`. When `bit_cnt` wraps from 7 to 0, the byte is complete: assert `byte_done` for 1 cycle.
- State machine states: WAIT_IDLE, TARGET, CMD, DATA.
  - WAIT_IDLE: entered on reset. Moves to TARGET when synced ss is high.
  - TARGET: on `byte_done`, latch `target` = byte and go to CMD. No strobe is issued for the target byte.
  - CMD: on `byte_done`, issue the selected strobe with `mcu_start`=1 and go to DATA.
  - DATA: on each `byte_done`, issue the selected strobe with `mcu_start`=0. Unlimited byte count.
  - Synced ss high in any state: go to TARGET, clear `bit_cnt`, and discard any partial byte (no strobe).
- Target codes: 0 = sys, 1 = hid, 2 = osd, 3 = sdc. Any other target byte means no strobes for the rest of the frame and MISO held at 0.
- `mcu_dout` is registered and loaded with `rx_shift` in the same cycle the strobe is asserted. It holds its value between strobes.
- MISO:
  - `tx_shift` is loaded from the selected `*_din` at the first synced SCK falling edge after a `byte_done`, and bit 7 is driven immediately.
  - Each subsequent SCK falling edge in the byte shifts the register left.
  - During the target byte, and for an invalid target, `spi_io_dout`=0.
  - With ss high, `spi_io_dout`=0.
- Reset values: all strobes 0, `mcu_start` 0, `mcu_dout` 0x00, `spi_io_dout` 0, `target` 0, `bit_cnt` 0, state WAIT_IDLE.

## Timing
- Latency from the 8th raw SCK rising edge to the strobe is 4 `clk` cycles: 2 sync + 1 edge detect + 1 register.
- Strobe width is exactly 1 `clk` cycle. At most 1 strobe is asserted per cycle.
- A consumer registers its reply ≤ 1 cycle after its strobe. With `clk` ≥ 8× SCK, the next falling edge comes ≥ 4 cycles after the 8th rising edge, so the reply is sampled after it updates.
- Simultaneous ss rise and `byte_done` in the same cycle: ss wins and no strobe is issued.
- Reset mid-frame: the block waits for ss high before accepting a new frame. The remaining bytes of the current frame are ignored.

## Structure
- Shared package `mcu_spi_pkg`: target code constants `TGT_SYS`=0, `TGT_HID`=1, `TGT_OSD`=2, `TGT_SDC`=3, and a state enum.
- Sub-module `spi_sync`: parameterised 2-flop synchroniser with a rising/falling edge-detect output. It is instanced for SCK and ss; MOSI uses the plain synchroniser.
- Expected size is around 180 lines of RTL.

## Test plan
- Frame `01 01 xx`, with `mcu_hid_din`=0x5A → `mcu_hid_strobe` pulses twice, `mcu_start`=1 on the first pulse, `mcu_dout` = 0x01 then 0xxx, MISO during the 3rd byte = 0x5A.
- Frame `01 03 00 81 00 00 00`: hid gets 6 strobes, `mcu_start` only on the first, bytes in order. No other strobe fires.
- Target byte 0x07 followed by 3 bytes → no strobes, MISO 0 for the whole frame.
- ss raised after 5 bits of the 2nd byte, then frame `02 10` → no strobe from the partial byte, then `mcu_osd_strobe` with `mcu_start`=1 and `mcu_dout`=0x10.
- `reset` pulsed mid-byte with ss held low → nothing is issued until ss goes high. The next frame `00 00` yields 1 `mcu_sys_strobe` with `mcu_start`=1.
- SCK at `clk`/8, back-to-back bytes with no gap: all bytes are strobed, and MISO matches a reply that changes per byte (0x01, 0x02, 0x03).
